// File: rtl/rv32i_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rv32i_pkg
//  Description : Shared RV32I opcodes, immediate formats and decode packet
//                types used by the decode stage and its immediate generator.
//  Revision    : 1.0 - initial release
// ============================================================================
package rv32i_pkg;

    localparam int XLEN = 32;
    localparam int PC_W = 32;

    // Base opcodes (insn[6:0]) accepted as RV32I
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_REG    = 7'h33;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_FENCE  = 7'h0F;
    localparam logic [6:0] OP_SYSTEM = 7'h73;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } imm_fmt_e;

    typedef struct packed {
        logic [6:0] opcode;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [2:0] funct3;
        logic [6:0] funct7;
    } dec_fields_t;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [XLEN-1:0] insn;
        dec_fields_t     fields;
        logic [XLEN-1:0] imm;
        logic            illegal;
    } dec_pkt_t;

    // Fixed-position register/function fields, independent of format
    function automatic dec_fields_t split_fields(input logic [XLEN-1:0] insn);
        dec_fields_t f;
        f.opcode = insn[6:0];
        f.rd     = insn[11:7];
        f.rs1    = insn[19:15];
        f.rs2    = insn[24:20];
        f.funct3 = insn[14:12];
        f.funct7 = insn[31:25];
        return f;
    endfunction

endpackage
`default_nettype wire

// File: rtl/imm_gen.sv
`default_nettype none
// ============================================================================
//  Module      : imm_gen
//  Description : Combinational RV32I format classifier, immediate
//                sign-extension and illegal-encoding detection.
//  Revision    : 1.0 - initial release
// ============================================================================
module imm_gen
    import rv32i_pkg::*;
(
    input  logic [XLEN-1:0] insn,
    output imm_fmt_e        fmt,
    output logic [XLEN-1:0] imm,
    output logic            illegal
);

    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic [6:0] w_funct7;
    logic       w_sign;
    logic       w_shift_imm;

    assign w_opcode    = insn[6:0];
    assign w_funct3    = insn[14:12];
    assign w_funct7    = insn[31:25];
    assign w_sign      = insn[31];
    // slli/srli/srai carry a 5-bit shamt, not a signed immediate
    assign w_shift_imm = (w_opcode == OP_IMM) && (w_funct3[1:0] == 2'b01);

    // Classify format and flag encodings outside RV32I
    always_comb begin
        fmt     = FMT_R;
        illegal = 1'b0;
        case (w_opcode)
            OP_LOAD: begin
                fmt     = FMT_I;
                illegal = (w_funct3 == 3'b011) || (w_funct3 == 3'b110) || (w_funct3 == 3'b111);
            end
            OP_IMM, OP_SYSTEM: fmt = FMT_I;
            OP_AUIPC, OP_LUI:  fmt = FMT_U;
            OP_STORE: begin
                fmt     = FMT_S;
                illegal = (w_funct3 > 3'b010);
            end
            OP_REG: begin
                fmt     = FMT_R;
                illegal = !((w_funct7 == 7'h00) ||
                            ((w_funct7 == 7'h20) && ((w_funct3 == 3'b000) || (w_funct3 == 3'b101))));
            end
            OP_BRANCH: begin
                fmt     = FMT_B;
                illegal = (w_funct3 == 3'b010) || (w_funct3 == 3'b011);
            end
            OP_JALR: begin
                fmt     = FMT_I;
                illegal = (w_funct3 != 3'b000);
            end
            OP_JAL:   fmt = FMT_J;
            OP_FENCE: fmt = FMT_R;
            default:  illegal = 1'b1;
        endcase
    end

    // Assemble the sign-extended immediate; illegal words carry zero
    always_comb begin
        imm = '0;
        case (fmt)
            FMT_I: imm = w_shift_imm ? {27'd0, insn[24:20]}
                                     : {{20{w_sign}}, insn[31:20]};
            FMT_S: imm = {{20{w_sign}}, insn[31:25], insn[11:7]};
            FMT_B: imm = {{19{w_sign}}, insn[31], insn[7], insn[30:25], insn[11:8], 1'b0};
            FMT_U: imm = {insn[31:12], 12'd0};
            FMT_J: imm = {{11{w_sign}}, insn[31], insn[19:12], insn[20], insn[30:21], 1'b0};
            default: imm = '0;
        endcase
        if (illegal) imm = '0;
    end

endmodule
`default_nettype wire

// File: rtl/decode.sv
`default_nettype none
// ============================================================================
//  Module      : decode
//  Description : RV32I decode stage behind a 2-entry skid buffer with a
//                registered ready_o toward fetch.
//  Revision    : 1.0 - initial release
// ============================================================================
module decode
    import rv32i_pkg::*;
#(
    parameter int AWIDTH = 32,
    parameter int DWIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [AWIDTH-1:0] pc_i,
    input  logic [DWIDTH-1:0] insn_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [AWIDTH-1:0] pc_o,
    output logic [DWIDTH-1:0] insn_o,
    output logic [6:0]        opcode_o,
    output logic [4:0]        rd_o,
    output logic [4:0]        rs1_o,
    output logic [4:0]        rs2_o,
    output logic [2:0]        funct3_o,
    output logic [6:0]        funct7_o,
    output logic [DWIDTH-1:0] imm_o,
    output logic              illegal_o
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_e;

    state_e          r_state;
    state_e          w_next;
    logic            r_ready;
    dec_pkt_t        r_main;
    dec_pkt_t        r_skid;
    dec_pkt_t        w_in_pkt;
    logic            w_in_xfer;
    logic            w_out_xfer;
    logic            w_load_main;
    logic            w_main_from_skid;
    logic            w_load_skid;
    logic [XLEN-1:0] w_imm;
    logic            w_illegal;
    imm_fmt_e        w_fmt_unused;

    imm_gen u_imm_gen (
        .insn    (insn_i),
        .fmt     (w_fmt_unused),
        .imm     (w_imm),
        .illegal (w_illegal)
    );

    assign w_in_pkt.pc      = pc_i;
    assign w_in_pkt.insn    = insn_i;
    assign w_in_pkt.fields  = split_fields(insn_i);
    assign w_in_pkt.imm     = w_imm;
    assign w_in_pkt.illegal = w_illegal;

    assign valid_o    = (r_state != S_EMPTY);
    assign ready_o    = r_ready;
    assign w_in_xfer  = valid_i & r_ready;
    assign w_out_xfer = valid_o & ready_i;

    // Next-state and buffer steering; flush overrides every transfer
    always_comb begin
        w_next           = r_state;
        w_load_main      = 1'b0;
        w_main_from_skid = 1'b0;
        w_load_skid      = 1'b0;
        case (r_state)
            S_EMPTY: begin
                if (w_in_xfer) begin
                    w_next      = S_ONE;
                    w_load_main = 1'b1;
                end
            end
            S_ONE: begin
                if (w_in_xfer && !w_out_xfer) begin
                    w_next      = S_FULL;
                    w_load_skid = 1'b1;
                end else if (!w_in_xfer && w_out_xfer) begin
                    w_next = S_EMPTY;
                end else if (w_in_xfer && w_out_xfer) begin
                    w_load_main = 1'b1;
                end
            end
            S_FULL: begin
                if (w_out_xfer) begin
                    w_next           = S_ONE;
                    w_main_from_skid = 1'b1;
                end
            end
            default: w_next = S_EMPTY;
        endcase
        if (flush_i) begin
            w_next           = S_EMPTY;
            w_load_main      = 1'b0;
            w_main_from_skid = 1'b0;
            w_load_skid      = 1'b0;
        end
    end

    // State, registered ready and the two packet registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_EMPTY;
            r_ready <= 1'b1;
            r_main  <= '0;
            r_skid  <= '0;
        end else begin
            r_state <= w_next;
            r_ready <= (w_next != S_FULL);
            if (w_load_main)           r_main <= w_in_pkt;
            else if (w_main_from_skid) r_main <= r_skid;
            if (w_load_skid)           r_skid <= w_in_pkt;
        end
    end

    assign pc_o      = r_main.pc;
    assign insn_o    = r_main.insn;
    assign opcode_o  = r_main.fields.opcode;
    assign rd_o      = r_main.fields.rd;
    assign rs1_o     = r_main.fields.rs1;
    assign rs2_o     = r_main.fields.rs2;
    assign funct3_o  = r_main.fields.funct3;
    assign funct7_o  = r_main.fields.funct7;
    assign imm_o     = r_main.imm;
    assign illegal_o = r_main.illegal;

endmodule
`default_nettype wire
